// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//
// Shares the single SDRAM port between three requesters: the host loader copy
// engine (hst), the CPU bus (cpu) and the floppy/disk DMA (dsk). One access
// is in flight at a time. The winner's request is latched, the SDRAM is
// strobed, the arbiter waits for the SDRAM to go busy and come back ready,
// then returns read data with a one-cycle ack to the owning requester.
// Each requester uses a four-phase req/ack handshake.
//
// Parameters
//   TIMEOUT   clk_sys cycles spent waiting for ram_ready before an access is
//             abandoned (must be >= 2)
//   ERR_DATA  rdata value returned when a read times out
//
// Ports
//   clk_sys                         system clock, rising edge
//   reset_n                         asynchronous active-low reset
//   hst_/cpu_/dsk_req               level request, held until the matching ack
//   hst_/cpu_/dsk_we                1 = write, 0 = read
//   hst_/cpu_/dsk_addr   [24:0]     byte address, bit 0 ignored
//   hst_/cpu_/dsk_din    [15:0]     write data
//   hst_/cpu_/dsk_wtbt   [1:0]      byte enables ([1] high byte, [0] low byte)
//   hst_/cpu_/dsk_ack               one-cycle completion pulse
//   rdata                [15:0]     read data, valid from ack until next completion
//   owner                [1:0]      current grant: 0 none, 1 hst, 2 cpu, 3 dsk
//   err                             sticky timeout flag, cleared only by reset
//   ram_rd / ram_we                 one-cycle read / write strobes to the SDRAM
//   ram_addr             [24:0]     latched address, bit 0 forced to 0
//   ram_din              [15:0]     latched write data
//   ram_wtbt             [1:0]      latched byte enables
//   ram_dout             [15:0]     SDRAM read data
//   ram_ready                       SDRAM idle / complete indicator
// ---------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,

  input  logic        hst_req,
  input  logic        hst_we,
  input  logic [24:0] hst_addr,
  input  logic [15:0] hst_din,
  input  logic [1:0]  hst_wtbt,
  output logic        hst_ack,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_wtbt,
  output logic        cpu_ack,

  input  logic        dsk_req,
  input  logic        dsk_we,
  input  logic [24:0] dsk_addr,
  input  logic [15:0] dsk_din,
  input  logic [1:0]  dsk_wtbt,
  output logic        dsk_ack,

  output logic [15:0] rdata,
  output logic [1:0]  owner,
  output logic        err,

  output logic        ram_rd,
  output logic        ram_we,
  output logic [24:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [1:0]  ram_wtbt,
  input  logic [15:0] ram_dout,
  input  logic        ram_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_HST  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_DSK  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        we_q, we_d;
  logic [24:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [1:0]  wtbt_q, wtbt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        rr_cpu_q, rr_cpu_d;

  logic [1:0]  winner;
  logic        owner_req;
  logic [2:0]  owner_ack;
  logic        timed_out;

  // Pick the requester that would be granted if we are in IDLE this cycle.
  // hst has absolute priority; between cpu and dsk the round-robin pointer
  // only matters when both are asking at the same time.
  always_comb begin
    winner = OWN_NONE;
    if (hst_req) begin
      winner = OWN_HST;
    end else if (cpu_req && dsk_req) begin
      winner = rr_cpu_q ? OWN_CPU : OWN_DSK;
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end else if (dsk_req) begin
      winner = OWN_DSK;
    end
  end

  // Route the current owner's request line in, and build the one-hot ack
  // vector that targets only that owner (bit 0 hst, bit 1 cpu, bit 2 dsk).
  always_comb begin
    owner_req = 1'b0;
    owner_ack = 3'b000;
    case (owner_q)
      OWN_HST: begin
        owner_req = hst_req;
        owner_ack = 3'b001;
      end
      OWN_CPU: begin
        owner_req = cpu_req;
        owner_ack = 3'b010;
      end
      OWN_DSK: begin
        owner_req = dsk_req;
        owner_ack = 3'b100;
      end
      default: begin
        owner_req = 1'b0;
        owner_ack = 3'b000;
      end
    endcase
  end

  // The counter holds the number of cycles already spent waiting; once the
  // current waiting cycle is the TIMEOUT-th one, the access is abandoned.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-register logic for the access sequencer. Acks are
  // registered pulses, so they default to zero and are only set on the edge
  // that completes (or abandons) an access.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wtbt_d   = wtbt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ack_d    = 3'b000;
    cnt_d    = cnt_q;
    rr_cpu_d = rr_cpu_q;

    case (state_q)
      IDLE: begin
        if (ram_ready && (winner != OWN_NONE)) begin
          owner_d = winner;
          state_d = ISSUE;
          case (winner)
            OWN_HST: begin
              we_d   = hst_we;
              addr_d = hst_addr & ~25'd1;
              din_d  = hst_din;
              wtbt_d = hst_wtbt;
            end
            OWN_CPU: begin
              we_d     = cpu_we;
              addr_d   = cpu_addr & ~25'd1;
              din_d    = cpu_din;
              wtbt_d   = cpu_wtbt;
              rr_cpu_d = 1'b0;
            end
            default: begin
              we_d     = dsk_we;
              addr_d   = dsk_addr & ~25'd1;
              din_d    = dsk_din;
              wtbt_d   = dsk_wtbt;
              rr_cpu_d = 1'b1;
            end
          endcase
        end
      end

      ISSUE: begin
        cnt_d = '0;
        // A write with no byte lanes enabled has nothing to do in the SDRAM,
        // so it completes right away without a strobe.
        if (we_q && (wtbt_q == 2'b00)) begin
          ack_d   = owner_ack;
          state_d = DONE;
        end else begin
          state_d = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (timed_out) begin
          ack_d   = owner_ack;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!ram_ready) begin
            state_d = WAIT_HI;
          end
        end
      end

      WAIT_HI: begin
        if (ram_ready) begin
          ack_d   = owner_ack;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = ram_dout;
          end
        end else if (timed_out) begin
          ack_d   = owner_ack;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Wait for the owner to drop its level request so the same request
        // is never serviced twice.
        if (!owner_req) begin
          owner_d = OWN_NONE;
          state_d = IDLE;
        end
      end

      default: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is asynchronous so an access in
  // flight is dropped and every output clears without waiting for a clock.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      wtbt_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ack_q    <= 3'b000;
      cnt_q    <= '0;
      rr_cpu_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wtbt_q   <= wtbt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      rr_cpu_q <= rr_cpu_d;
    end
  end

  // Strobes are decoded from the ISSUE state only, which keeps them one
  // cycle wide and mutually exclusive.
  assign ram_rd   = (state_q == ISSUE) && !we_q;
  assign ram_we   = (state_q == ISSUE) && we_q && (wtbt_q != 2'b00);
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign ram_wtbt = wtbt_q;

  assign hst_ack  = ack_q[0];
  assign cpu_ack  = ack_q[1];
  assign dsk_ack  = ack_q[2];

  assign rdata    = rdata_q;
  assign owner    = owner_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Directed bench for sdram_arbiter. Stimulus pushes the expected SDRAM strobes
// and the expected acks into two queues; independent monitors pop and compare
// whenever the DUT strobes the SDRAM or pulses an ack. A small behavioural
// SDRAM drops ram_ready for a programmable number of cycles after each strobe.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;

  logic        hst_req, hst_we, cpu_req, cpu_we, dsk_req, dsk_we;
  logic [24:0] hst_addr, cpu_addr, dsk_addr;
  logic [15:0] hst_din, cpu_din, dsk_din;
  logic [1:0]  hst_wtbt, cpu_wtbt, dsk_wtbt;
  logic        hst_ack, cpu_ack, dsk_ack;
  logic [15:0] rdata;
  logic [1:0]  owner;
  logic        err;
  logic        ram_rd, ram_we;
  logic [24:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_wtbt;
  logic [15:0] ram_dout;
  logic        ram_ready;

  typedef struct {
    int          who;
    bit          is_read;
    logic [15:0] data;
  } ack_exp_t;

  typedef struct {
    bit          is_write;
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
  } strobe_exp_t;

  ack_exp_t    ack_q[$];
  strobe_exp_t strobe_q[$];
  ack_exp_t    mon_ack;
  strobe_exp_t mon_strobe;
  int          mon_who;

  int n_checks = 0;
  int n_pass   = 0;

  int          model_busy  = 3;
  logic [15:0] model_rdata = 16'h0000;
  bit          model_stuck = 1'b0;

  // 100 MHz style clock, rising edges at 5, 15, 25 ...
  always #5 clk_sys = ~clk_sys;

  sdram_arbiter #(
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (16'hFFFF)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .hst_req   (hst_req),
    .hst_we    (hst_we),
    .hst_addr  (hst_addr),
    .hst_din   (hst_din),
    .hst_wtbt  (hst_wtbt),
    .hst_ack   (hst_ack),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_wtbt  (cpu_wtbt),
    .cpu_ack   (cpu_ack),
    .dsk_req   (dsk_req),
    .dsk_we    (dsk_we),
    .dsk_addr  (dsk_addr),
    .dsk_din   (dsk_din),
    .dsk_wtbt  (dsk_wtbt),
    .dsk_ack   (dsk_ack),
    .rdata     (rdata),
    .owner     (owner),
    .err       (err),
    .ram_rd    (ram_rd),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_wtbt  (ram_wtbt),
    .ram_dout  (ram_dout),
    .ram_ready (ram_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic failNow(input string name, input string detail);
    n_checks++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic applyStimulus(input int who, input logic req, input logic we,
                               input logic [24:0] addr, input logic [15:0] din,
                               input logic [1:0] wtbt);
    case (who)
      1: begin hst_we = we; hst_addr = addr; hst_din = din; hst_wtbt = wtbt; hst_req = req; end
      2: begin cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_wtbt = wtbt; cpu_req = req; end
      default: begin dsk_we = we; dsk_addr = addr; dsk_din = din; dsk_wtbt = wtbt; dsk_req = req; end
    endcase
  endtask

  task automatic setReq(input int who, input logic req);
    case (who)
      1: hst_req = req;
      2: cpu_req = req;
      default: dsk_req = req;
    endcase
  endtask

  function automatic logic ackOf(input int who);
    case (who)
      1: return hst_ack;
      2: return cpu_ack;
      default: return dsk_ack;
    endcase
  endfunction

  task automatic expectAck(input int who, input bit is_read, input logic [15:0] data);
    ack_exp_t e;
    e.who = who; e.is_read = is_read; e.data = data;
    ack_q.push_back(e);
  endtask

  task automatic expectStrobe(input bit is_write, input logic [24:0] addr,
                              input logic [15:0] din, input logic [1:0] wtbt);
    strobe_exp_t e;
    e.is_write = is_write; e.addr = addr; e.din = din; e.wtbt = wtbt;
    strobe_q.push_back(e);
  endtask

  // Polls one cycle at a time (1 ns after each rising edge) until the given
  // requester sees its ack; cycles is counted from the call.
  task automatic waitAck(input int who, input int limit, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(posedge clk_sys); #1;
      cycles++;
      seen = ackOf(who);
    end
    if (!seen)
      failNow("ack_wait", $sformatf("got no ack for requester %0d in %0d cycles, expected one", who, limit));
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  // Four-phase requester issuing n back-to-back writes, re-requesting on the
  // cycle right after it drops req.
  task automatic requester(input int who, input int n, input logic [24:0] base,
                           input logic [15:0] dbase);
    int lat;
    @(posedge clk_sys); #1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(who, 1'b1, 1'b1, base + 25'(2 * i), dbase + 16'(i), 2'b11);
      waitAck(who, 300, lat);
      setReq(who, 1'b0);
      @(posedge clk_sys); #1;
    end
  endtask

  // Behavioural SDRAM: after a strobe it drops ram_ready for model_busy
  // cycles (or until released when stuck), then presents model_rdata.
  initial begin
    ram_ready = 1'b1;
    ram_dout  = 16'h0000;
    forever begin
      @(negedge clk_sys);
      if (reset_n && (ram_rd || ram_we)) begin
        @(posedge clk_sys); #1;
        ram_ready = 1'b0;
        if (model_stuck) begin
          wait (!model_stuck);
          @(posedge clk_sys); #1;
        end else begin
          repeat (model_busy) @(posedge clk_sys);
          #1;
        end
        ram_dout  = model_rdata;
        ram_ready = 1'b1;
      end
    end
  end

  // Ack monitor: every ack must be one-hot, go to the current owner and
  // match the next expected completion.
  always @(negedge clk_sys) begin
    if (reset_n && (hst_ack || cpu_ack || dsk_ack)) begin
      checkOutput("ack_onehot", $countones({hst_ack, cpu_ack, dsk_ack}), 1);
      mon_who = hst_ack ? 1 : (cpu_ack ? 2 : 3);
      if (ack_q.size() == 0) begin
        failNow("unexpected_ack", $sformatf("got ack to requester %0d, expected none", mon_who));
      end else begin
        mon_ack = ack_q.pop_front();
        checkOutput("ack_requester", mon_who, mon_ack.who);
        checkOutput("ack_owner", owner, mon_ack.who);
        if (mon_ack.is_read) checkOutput("ack_rdata", rdata, mon_ack.data);
      end
    end
  end

  // Strobe monitor: sampled once per cycle, so a strobe wider than one cycle
  // shows up as an unexpected second strobe.
  always @(negedge clk_sys) begin
    if (reset_n && (ram_rd || ram_we)) begin
      checkOutput("strobe_exclusive", ram_rd && ram_we, 0);
      if (strobe_q.size() == 0) begin
        failNow("unexpected_strobe", $sformatf("got rd=%0b we=%0b addr=0x%0h, expected no strobe",
                ram_rd, ram_we, ram_addr));
      end else begin
        mon_strobe = strobe_q.pop_front();
        checkOutput("strobe_kind", ram_we, mon_strobe.is_write);
        checkOutput("strobe_addr", ram_addr, mon_strobe.addr);
        if (mon_strobe.is_write) begin
          checkOutput("strobe_din", ram_din, mon_strobe.din);
          checkOutput("strobe_wtbt", ram_wtbt, mon_strobe.wtbt);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion well before", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    hst_req = 0; hst_we = 0; hst_addr = 0; hst_din = 0; hst_wtbt = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0; cpu_wtbt = 0;
    dsk_req = 0; dsk_we = 0; dsk_addr = 0; dsk_din = 0; dsk_wtbt = 0;

    // Reset state
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_acks", {hst_ack, cpu_ack, dsk_ack}, 0);
    checkOutput("rst_strobes", {ram_rd, ram_we}, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_din", ram_din, 0);
    checkOutput("rst_ram_wtbt", ram_wtbt, 0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // 1: single CPU read, 5 busy cycles -> ack 3 + 5 cycles after req
    $display("[TB] single cpu read");
    model_busy = 5; model_rdata = 16'o12345;
    expectStrobe(1'b0, 25'h04010, 16'h0, 2'b00);
    expectAck(2, 1'b1, 16'o12345);
    applyStimulus(2, 1'b1, 1'b0, 25'h04010, 16'h0, 2'b00);
    waitAck(2, 50, lat);
    checkOutput("t1_latency", lat, 8);
    checkOutput("t1_owner_busy", owner, 2);
    cpu_addr = 25'h1FFFFFF;
    checkOutput("t1_addr_held", ram_addr, 25'h04010);
    setReq(2, 1'b0);
    @(posedge clk_sys); #1;
    checkOutput("t1_owner_released", owner, 0);
    checkOutput("t1_rdata_held", rdata, 16'o12345);
    @(posedge clk_sys); #1;

    // 2: dsk byte write on an odd address, then a write with no byte lanes
    $display("[TB] dsk byte writes");
    model_busy = 3; model_rdata = 16'h0BAD;
    expectStrobe(1'b1, 25'h20002, 16'hA55A, 2'b10);
    expectAck(3, 1'b0, 16'h0);
    applyStimulus(3, 1'b1, 1'b1, 25'h20003, 16'hA55A, 2'b10);
    waitAck(3, 50, lat);
    checkOutput("t2_latency", lat, 6);
    setReq(3, 1'b0);
    @(posedge clk_sys); #1;
    checkOutput("t2_rdata_unchanged", rdata, 16'o12345);
    checkOutput("t2_wtbt_held", ram_wtbt, 2'b10);
    expectAck(3, 1'b0, 16'h0);
    applyStimulus(3, 1'b1, 1'b1, 25'h20004, 16'h1111, 2'b00);
    waitAck(3, 20, lat);
    checkOutput("t2_zero_be_latency", lat, 2);
    setReq(3, 1'b0);
    @(posedge clk_sys); #1;

    // 4: timeout. req -> ISSUE (1), ISSUE (1), then TIMEOUT waiting cycles
    $display("[TB] timeout");
    model_stuck = 1'b1; model_rdata = 16'h2222;
    expectStrobe(1'b0, 25'h00ABC, 16'h0, 2'b00);
    expectAck(2, 1'b1, 16'hFFFF);
    applyStimulus(2, 1'b1, 1'b0, 25'h00ABC, 16'h0, 2'b00);
    waitAck(2, 200, lat);
    checkOutput("t4_timeout_latency", lat, TIMEOUT + 2);
    checkOutput("t4_err_set", err, 1);
    setReq(2, 1'b0);
    model_stuck = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    model_busy = 2; model_rdata = 16'h1234;
    expectStrobe(1'b0, 25'h00100, 16'h0, 2'b00);
    expectAck(2, 1'b1, 16'h1234);
    applyStimulus(2, 1'b1, 1'b0, 25'h00100, 16'h0, 2'b00);
    waitAck(2, 50, lat);
    checkOutput("t4_good_latency", lat, 5);
    checkOutput("t4_err_sticky", err, 1);
    setReq(2, 1'b0);
    @(posedge clk_sys); #1;

    // 5: reset while the access sits in WAIT_HI
    $display("[TB] reset mid-access");
    model_busy = 20; model_rdata = 16'hDEAD;
    expectStrobe(1'b0, 25'h00200, 16'h0, 2'b00);
    applyStimulus(2, 1'b1, 1'b0, 25'h00200, 16'h0, 2'b00);
    repeat (5) @(posedge clk_sys);
    #3;
    checkOutput("t5_owner_in_flight", owner, 2);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_owner_async", owner, 0);
    checkOutput("t5_strobes_async", {ram_rd, ram_we}, 0);
    checkOutput("t5_acks_async", {hst_ack, cpu_ack, dsk_ack}, 0);
    checkOutput("t5_err_cleared", err, 0);
    checkOutput("t5_rdata_cleared", rdata, 0);
    checkOutput("t5_addr_cleared", ram_addr, 0);
    model_rdata = 16'h5A5A;
    expectStrobe(1'b0, 25'h00200, 16'h0, 2'b00);
    expectAck(2, 1'b1, 16'h5A5A);
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    waitAck(2, 150, lat);
    setReq(2, 1'b0);
    repeat (5) @(posedge clk_sys);
    #1;
    checkOutput("t5_ack_queue_drained", ack_q.size(), 0);

    // 6: request held high after its ack must not be re-serviced
    $display("[TB] held request");
    model_busy = 2; model_rdata = 16'h7777;
    expectStrobe(1'b0, 25'h00300, 16'h0, 2'b00);
    expectAck(2, 1'b1, 16'h7777);
    applyStimulus(2, 1'b1, 1'b0, 25'h00300, 16'h0, 2'b00);
    waitAck(2, 50, lat);
    repeat (10) @(posedge clk_sys);
    #1;
    checkOutput("t6_owner_held", owner, 2);
    setReq(2, 1'b0);
    @(posedge clk_sys); #1;
    checkOutput("t6_owner_released", owner, 0);
    model_rdata = 16'h8888;
    expectStrobe(1'b0, 25'h00302, 16'h0, 2'b00);
    expectAck(2, 1'b1, 16'h8888);
    applyStimulus(2, 1'b1, 1'b0, 25'h00302, 16'h0, 2'b00);
    waitAck(2, 50, lat);
    setReq(2, 1'b0);
    @(posedge clk_sys); #1;

    // 3: contention from a fresh reset (round-robin pointer at cpu)
    $display("[TB] contention");
    applyReset();
    model_busy = 2;
    expectStrobe(1'b1, 25'h01000, 16'h1000, 2'b11); expectAck(1, 1'b0, 16'h0);
    expectStrobe(1'b1, 25'h01002, 16'h1001, 2'b11); expectAck(1, 1'b0, 16'h0);
    expectStrobe(1'b1, 25'h02000, 16'h2000, 2'b11); expectAck(2, 1'b0, 16'h0);
    expectStrobe(1'b1, 25'h03000, 16'h3000, 2'b11); expectAck(3, 1'b0, 16'h0);
    expectStrobe(1'b1, 25'h02002, 16'h2001, 2'b11); expectAck(2, 1'b0, 16'h0);
    expectStrobe(1'b1, 25'h03002, 16'h3001, 2'b11); expectAck(3, 1'b0, 16'h0);
    fork
      requester(1, 2, 25'h01000, 16'h1000);
      requester(2, 2, 25'h02000, 16'h2000);
      requester(3, 2, 25'h03000, 16'h3000);
    join
    repeat (5) @(posedge clk_sys);
    #1;
    checkOutput("final_ack_queue", ack_q.size(), 0);
    checkOutput("final_strobe_queue", strobe_q.size(), 0);
    checkOutput("final_owner", owner, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM port of the memory subsystem between three requesters: host loader copy (hst), CPU bus (cpu) and floppy/disk DMA (dsk).
- Sits between the requesters and the sdram instance.
- Issues one access at a time: it latches the winner's request, strobes the SDRAM, waits for completion and returns the data with a per-requester ack.
- Each requester uses a four-phase req/ack handshake.

Parameters:
- TIMEOUT, 64: clk_sys cycles to wait for ram_ready to return before aborting an access.
- ERR_DATA, 16'hFFFF: rdata value returned on a timed-out read.

Ports:
- clk_sys  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- hst_req / cpu_req / dsk_req  input  1 each  access request, level; held until the matching ack.
- hst_we / cpu_we / dsk_we  input  1 each  1 = write, 0 = read.
- hst_addr / cpu_addr / dsk_addr  input  25 each  physical byte address; bit 0 is ignored.
- hst_din / cpu_din / dsk_din  input  16 each  write data.
- hst_wtbt / cpu_wtbt / dsk_wtbt  input  2 each  byte enables [1]=high byte, [0]=low byte.
- hst_ack / cpu_ack / dsk_ack  output  1 each  one-cycle completion pulse.
- rdata  output  16  read data; valid from the ack cycle until the next completion.
- owner  output  2  current grant: 0 none, 1 hst, 2 cpu, 3 dsk.
- err  output  1  sticky timeout flag; cleared only by reset.
- ram_rd  output  1  one-cycle read strobe to sdram.
- ram_we  output  1  one-cycle write strobe to sdram.
- ram_addr  output  25  latched address with bit 0 forced to 0.
- ram_din  output  16  latched write data.
- ram_wtbt  output  2  latched byte enables.
- ram_dout  input  16  sdram read data.
- ram_ready  input  1  sdram idle/complete indicator.

Behaviour:
- Reset (async, reset_n=0):
  - All acks, ram_rd, ram_we and err are 0; ram_addr, ram_din, ram_wtbt and rdata are 0; owner=0.
  - State = IDLE; round-robin pointer = cpu.
  - Outputs clear immediately, without a clock edge. An access in flight is abandoned, and no ack is issued for it after reset.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
- IDLE, on a cycle where ram_ready=1 and any req=1:
  - Arbitration: hst wins first (absolute priority). Otherwise, if both cpu and dsk request, the round-robin pointer decides; the pointer flips to the other requester after each cpu or dsk grant. If only one of cpu/dsk requests, it wins regardless of the pointer.
  - Latch the winner's addr, din, wtbt and we; set owner; go to ISSUE.
  - If ram_ready=0, stay in IDLE.
- ISSUE (1 cycle):
  - Assert ram_rd if we=0, or ram_we if we=1.
  - A write with wtbt=2'b00 asserts no strobe and goes straight to DONE with an ack. A read ignores wtbt.
  - Otherwise go to WAIT_LO and start the timeout counter.
- WAIT_LO: wait for ram_ready=0, then go to WAIT_HI.
- WAIT_HI: wait for ram_ready=1. On that cycle:
  - rdata <= ram_dout (reads only; writes leave rdata unchanged).
  - Pulse the owner's ack for exactly 1 cycle.
  - Go to DONE.
- Timeout:
  - If the counter reaches TIMEOUT in WAIT_LO or WAIT_HI, pulse the owner's ack, set rdata=ERR_DATA (reads only), set err=1 and go to DONE.
  - The counter is cleared on every ISSUE.
- DONE:
  - Hold owner until the owner's req=0, then owner=0 and go to IDLE.
  - A req still high in DONE is never re-serviced; this prevents double issue of a level request.
- Latency: from req at IDLE with ram_ready=1 to ack = 3 cycles plus SDRAM busy time. Minimum req-to-req throughput is ack + 2 cycles.
- Requester inputs changing after the grant are ignored; the latched copies are used.
- Requests arriving during a busy access wait. Arbitration is only evaluated in IDLE.
- ram_addr, ram_din and ram_wtbt stay stable from ISSUE until the next grant.
- Strobes are never asserted outside ISSUE; ram_rd and ram_we are never high together.

Test Plan:
1. Single CPU read: cpu_req=1, cpu_addr=25'h04010, cpu_we=0; model returns 16'o12345 after 5 busy cycles → ram_rd high exactly 1 cycle with ram_addr=25'h04010; cpu_ack one pulse; rdata=16'o12345; owner 2→0 after cpu_req drops.
2. Byte write: dsk write, addr=25'h20003, din=16'hA55A, wtbt=2'b10 → ram_we 1 cycle, ram_addr=25'h20002, ram_wtbt=2'b10; dsk_ack once. Repeat with wtbt=2'b00 → no ram_we; dsk_ack 2 cycles after grant.
3. Contention: hst, cpu and dsk all request continuously with immediate re-request after ack → grant order hst until hst_req drops, then cpu, dsk, cpu, dsk; no ack ever to a non-owner.
4. Timeout: ram_ready stuck at 0 after a read strobe → ack at TIMEOUT=64 cycles; rdata=16'hFFFF; err=1 and stays 1 through later good accesses.
5. Reset mid-access: reset_n=0 during WAIT_HI → ram_rd, ram_we, acks and owner are 0 immediately (before any clock edge); after release, a pending cpu_req is served fresh with exactly one ack.
6. Held request: cpu_req kept high for 10 cycles after its ack → no second ram_rd until cpu_req drops and rises again.
